// File: rtl/s_serial_sub_if.sv
// s_serial_sub_if: operand and result handshake bundle for the bit-serial
// signed subtractor.
//   in_valid / in_ready  : operand handshake (a, b accepted together)
//   a, b                 : N-bit two's-complement minuend / subtrahend
//   out_valid / out_ready: result handshake
//   out                  : N+1-bit sign-extended difference a - b
// master = operand producer / result consumer, slave = the subtractor.
interface s_serial_sub_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/s_serial_sub.sv
// s_serial_sub: bit-serial signed subtractor, out = a - b at N+1 bits.
// Computes a + ~b + 1 one bit per clock, LSB first, with the carry kept in
// a flop. A final cycle builds the sign-extension bit from the operand MSBs
// and the last carry, so the result is exact for every operand pair.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : s_serial_sub_if slave (in_valid/in_ready/a/b, out_valid/out_ready/out)
// Latency: accept at edge E, out_valid high after edge E+N+1.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | N cycles, one difference bit per cycle
// EXT   | one cycle, writes the sign-extension bit, raises out_valid
// DONE  | result held until out_ready
module s_serial_sub #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  s_serial_sub_if.slave bus
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EXT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic           sa_msb;
  logic           sb_msb;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [N:0]     out_r;
  logic           out_valid_r;

  logic           accept;
  logic           drain;
  logic           sum_bit;
  logic           carry_nxt;

  // Full adder on the current LSBs; sb already holds ~b.
  assign sum_bit   = sa[0] ^ sb[0] ^ carry;
  assign carry_nxt = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drain     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(N - 1)) begin
          state_nxt = EXT;
        end
      end
      EXT: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          drain     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa          <= '0;
      sb          <= '0;
      sa_msb      <= 1'b0;
      sb_msb      <= 1'b0;
      carry       <= 1'b0;
      cnt         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sa     <= bus.a;
            sb     <= ~bus.b;
            // MSBs survive the shifting for the sign-extension step.
            sa_msb <= bus.a[N-1];
            sb_msb <= ~bus.b[N-1];
            // Carry-in of 1 completes the two's-complement negation of b.
            carry  <= 1'b1;
            cnt    <= '0;
            out_r  <= '0;
          end
        end
        RUN: begin
          out_r[cnt] <= sum_bit;
          carry      <= carry_nxt;
          sa         <= {1'b0, sa[N-1:1]};
          sb         <= {1'b0, sb[N-1:1]};
          cnt        <= cnt + 1'b1;
        end
        EXT: begin
          // Bit N of sext(a) + sext(~b) + 1: both extension bits plus carry.
          out_r[N]    <= sa_msb ^ sb_msb ^ carry;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (drain) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_serial_sub.sv
module tb_s_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  s_serial_sub_if #(.N(8))  bus8 ();
  s_serial_sub_if #(.N(13)) bus13 ();

  s_serial_sub #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  s_serial_sub #(.N(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge after the
  // result leaves (out_ready high) or at the first negedge showing out_valid.
  task automatic xact8(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [8:0] exp, input string tag);
    int k;
    chk({tag, "_rdy"}, bus8.in_ready, 1);
    bus8.a        = ta;
    bus8.b        = tb_;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk({tag, "_busy"}, bus8.in_ready, 0);
    k = 0;
    while (!bus8.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, 9);
    chk({tag, "_out"}, bus8.out, exp);
    chk({tag, "_busy_done"}, bus8.in_ready, 0);
    if (bus8.out_ready) begin
      @(negedge clk);
      chk({tag, "_pulse"}, bus8.out_valid, 0);
      chk({tag, "_idle"}, bus8.in_ready, 1);
    end
  endtask

  task automatic xact13(input logic [12:0] ta, input logic [12:0] tb_,
                        input logic [13:0] exp);
    int k;
    chk("r13_rdy", bus13.in_ready, 1);
    bus13.a        = ta;
    bus13.b        = tb_;
    bus13.in_valid = 1'b1;
    @(negedge clk);
    bus13.in_valid = 1'b0;
    k = 0;
    while (!bus13.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("r13_lat", k, 14);
    chk("r13_out", bus13.out, exp);
    @(negedge clk);
    chk("r13_pulse", bus13.out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              seen;
    logic [7:0]        ra;
    logic [7:0]        rb;
    logic signed [8:0] re;
    logic [12:0]       ra13;
    logic [12:0]       rb13;
    logic signed [13:0] re13;

    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b1;
    bus13.in_valid  = 1'b0;
    bus13.a         = '0;
    bus13.b         = '0;
    bus13.out_ready = 1'b1;

    #1;
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_out", bus8.out, 0);
    chk("rst_in_ready", bus8.in_ready, 1);

    // Release reset and offer operands for the very first edge.
    @(negedge clk);
    rst_n = 1'b1;
    xact8(8'd5,   8'd3,   9'h002, "sub_5_3");
    xact8(8'h80,  8'h7F,  9'h101, "min_minus_max");
    xact8(8'h7F,  8'h80,  9'h0FF, "max_minus_min");
    xact8(8'h00,  8'h00,  9'h000, "zero");
    xact8(8'hFF,  8'h01,  9'h1FE, "m1_minus_1");
    xact8(8'h80,  8'h80,  9'h000, "min_minus_min");

    // Result held under back-pressure; new operands ignored.
    bus8.out_ready = 1'b0;
    xact8(8'd10, 8'd20, 9'h1F6, "hold");
    for (int i = 0; i < 6; i++) begin
      bus8.in_valid = i[0];
      bus8.a        = 8'(i + 1);
      bus8.b        = 8'(i + 3);
      @(negedge clk);
      chk("hold_out", bus8.out, 9'h1F6);
      chk("hold_valid", bus8.out_valid, 1);
      chk("hold_ready", bus8.in_ready, 0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", bus8.out_valid, 0);
    chk("hold_release_ready", bus8.in_ready, 1);
    chk("hold_keep_out", bus8.out, 9'h1F6);
    @(negedge clk);
    chk("hold_no_accept", bus8.in_ready, 1);

    // Reset in the middle of RUN.
    bus8.a        = 8'd3;
    bus8.b        = 8'd4;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", bus8.out_valid, 0);
    chk("midrun_rst_out", bus8.out, 0);
    chk("midrun_rst_ready", bus8.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1'b1;
    end
    chk("midrun_no_result", seen, 0);
    xact8(8'hF9, 8'h09, 9'h1F0, "post_rst");

    // Reset while a result waits in DONE.
    bus8.out_ready = 1'b0;
    xact8(8'd100, 8'hCE, 9'h096, "done_rst");
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", bus8.out_valid, 0);
    chk("done_rst_out", bus8.out, 0);
    chk("done_rst_ready", bus8.in_ready, 1);
    @(negedge clk);
    rst_n          = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("done_rst_stays", bus8.out_valid, 0);

    // Random back-to-back against an arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) rb = 8'h80;
      re = $signed(ra) - $signed(rb);
      xact8(ra, rb, re, "rnd8");
    end
    for (int i = 0; i < 300; i++) begin
      ra13 = 13'($urandom);
      rb13 = 13'($urandom);
      if (i == 0) begin
        ra13 = 13'h0FFF;
        rb13 = 13'h1000;
      end
      re13 = $signed(ra13) - $signed(rb13);
      xact13(ra13, rb13, re13);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
